seq_divider: RTL and testbench
==============================

# seq_divider

Sequential restoring divider: the inverse datapath of the shift-add multiplier. Divides a 2N-bit dividend by an N-bit divisor one quotient bit per clock, then converts the quotient to packed BCD with a sequential double-dabble stage. It sits beside the multiplier in the arithmetic unit and uses the same start/finish-style handshake and BCD output sizing, so results can be displayed directly.

## Interface
- N, 8, divisor width; dividend and quotient are 2N bits wide.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  2N  numerator, captured on accepted start.
- divisor  in  N  denominator, captured on accepted start.
- quotient  out  2N  registered result.
- remainder  out  N  registered result.
- bcd  out  ((2N/3)+1)*4  packed BCD of quotient, LS digit in bits [3:0].
- busy  out  1  high while DIV or BCD is in progress.
- done  out  1  high in DONE; results valid.
- div_by_zero  out  1  high in DONE when the captured divisor was 0.

## Operation
- States: IDLE, DIV, BCD, DONE.
- IDLE/DONE with start=1 at a clock edge: capture dividend and divisor, clear working registers, set count=2N.
  - If the divisor is nonzero, go to DIV.
  - If the divisor is 0, go directly to DONE with quotient=all ones, remainder=0, bcd=0, div_by_zero=1.
- DIV, each cycle:
  - partial remainder p (N+1 bits) = {p[N-1:0], dividend MSB}; shift dividend left.
  - If p >= {1'b0,divisor}: p -= divisor and shift 1 into the quotient LSB; otherwise shift 0.
  - Decrement count. At count 0, go to BCD with count=2N.
- BCD, each cycle: add 3 to every BCD digit >= 5, then shift {bcd, quotient} left by 1. After 2N shifts, go to DONE.
- Entering DONE loads the quotient, remainder, bcd and div_by_zero outputs from the working registers in one edge. Outputs hold their previous values during DIV and BCD.
- start in DIV or BCD is ignored. Inputs are not re-sampled mid-operation.
- DONE holds until an accepted start. done drops on the edge that accepts the new start.
- Invariant when div_by_zero=0: dividend = quotient*divisor + remainder, and remainder < divisor.

## Timing
- Reset, asynchronous: state=IDLE. quotient, remainder, bcd, busy, done and div_by_zero are all 0. Working registers are cleared.
- Reset asserted mid-operation aborts immediately to the same values. No partial result is exposed.
- Start accepted at edge 0:
  - busy=1 after edge 0.
  - DIV occupies edges 1..2N.
  - BCD occupies edges 2N+1..4N.
  - done=1 and busy=0 after edge 4N (32 cycles for N=8).
- Divide-by-zero: done=1 after edge 0 and busy stays 0.
- Back-to-back operation: start held high in DONE launches the next operation with no idle cycle.
- BCD width covers the maximum quotient 2^(2N)-1. The top digit is 0 for N=8.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, DIV, BCD, DONE);
  - function bcd_width(n) returning ((2n/3)+1)*4;
  - localparam CNT_W = $clog2(2N+1).
- Sub-module bin2bcd_seq: the double-dabble engine. Parameterised by binary width; has load, shift enable and bcd output; instantiated for the BCD phase. The divider core stays in seq_divider.

## Test plan
- 1000 / 7 -> quotient=142, remainder=6, bcd=0x000142, div_by_zero=0, done exactly 32 cycles after start.
- 65535 / 255 -> quotient=257, remainder=0. Then 65535 / 1 -> quotient=65535, bcd=0x065535.
- 5 / 9 -> quotient=0, remainder=5, bcd=0; and 0 / 200 -> quotient=0, remainder=0.
- divisor=0, dividend=1234 -> done=1 next cycle, div_by_zero=1, quotient=0xFFFF, remainder=0, busy never high.
- Start pulsed again at cycle 10 of a busy operation -> ignored. The original result appears at cycle 32 and outputs hold the prior values until then.
- Reset asserted at cycle 12, then released -> all outputs 0 and state IDLE. A new 100 / 3 then yields quotient=33, remainder=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider and its BCD stage.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DIV_N = 8;
  localparam int CNT_W = $clog2(2*DIV_N + 1);

  // Digits needed to hold a 2n-bit binary value, four bits each.
  function automatic int bcd_width(input int n);
    return ((2*n/3) + 1) * 4;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Double-dabble engine: one add-3/shift step per enabled cycle.
// bcd_o is the value the digits will hold after the pending shift step.
module bin2bcd_seq import div_pkg::*; #(
  parameter int BIN_W = 16,
  parameter int BCD_W = bcd_width(BIN_W/2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d, adj;
  logic [BCD_W+BIN_W-1:0] cat;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W/4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    cat   = {adj, bin_q} << 1;
    bcd_d = cat[BCD_W+BIN_W-1:BIN_W];
    bin_d = cat[BIN_W-1:0];
  end

  assign bcd_o = bcd_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
    end else if (shift_i) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, followed by sequential
// binary-to-BCD conversion of the quotient.
module seq_divider import div_pkg::*; #(
  parameter int N = DIV_N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*N-1:0]          dividend,
  input  logic [N-1:0]            divisor,
  output logic [2*N-1:0]          quotient,
  output logic [N-1:0]            remainder,
  output logic [bcd_width(N)-1:0] bcd,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero
);

  localparam int QW = 2*N;
  localparam int BW = bcd_width(N);
  localparam int CW = $clog2(2*N + 1);

  state_e        state_q;
  logic [QW-1:0] dvd_q, quo_q, quo_d;
  logic [N-1:0]  dvs_q;
  logic [N:0]    p_q, p_d, p_sh;
  logic [CW-1:0] cnt_q;
  logic          ge;
  logic [BW-1:0] bcd_nxt;

  assign p_sh  = {p_q[N-1:0], dvd_q[QW-1]};
  assign ge    = p_sh >= {1'b0, dvs_q};
  assign p_d   = ge ? p_sh - {1'b0, dvs_q} : p_sh;
  assign quo_d = {quo_q[QW-2:0], ge};

  // The engine is loaded with the final quotient on the last DIV edge.
  bin2bcd_seq #(.BIN_W(QW), .BCD_W(BW)) u_bcd (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_q == DIV && cnt_q == CW'(1)),
    .shift_i (state_q == BCD),
    .bin_i   (quo_d),
    .bcd_o   (bcd_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      bcd         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          dvd_q <= dividend;
          dvs_q <= divisor;
          quo_q <= '0;
          p_q   <= '0;
          cnt_q <= CW'(QW);
          if (divisor == '0) begin
            state_q     <= DONE;
            quotient    <= '1;
            remainder   <= '0;
            bcd         <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            state_q <= DIV;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        DIV: begin
          p_q   <= p_d;
          quo_q <= quo_d;
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= BCD;
            cnt_q   <= CW'(QW);
          end
        end
        BCD: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            quotient    <= quo_q;
            remainder   <= p_q[N-1:0];
            bcd         <= bcd_nxt;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at launch, popped at done.
module tb_seq_divider;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic [23:0] bcd;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic [23:0] bcd;
  logic        busy, done, div_by_zero;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t last_e;

  seq_divider #(.N(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .bcd         (bcd),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] b;
    b = '0;
    for (int i = 0; i < 6; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = 8'd0; e.bcd = 24'd0; e.dbz = 1'b1;
    end else begin
      e.q = a / 16'(b); e.r = 8'(a % 16'(b)); e.bcd = to_bcd(32'(e.q)); e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Returns at the negedge just after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    n_checks++;
    if ({quotient, remainder, bcd, busy, done, div_by_zero} !== '0)
      $display("FAIL reset_asserted: got q=%h r=%h bcd=%h busy=%b done=%b dbz=%b, required all 0",
               quotient, remainder, bcd, busy, done, div_by_zero);
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({quotient, remainder, bcd, busy, done, div_by_zero} !== '0)
      $display("FAIL reset_idle: got q=%h r=%h bcd=%h busy=%b done=%b, required all 0",
               quotient, remainder, bcd, busy, done);
    else n_pass++;
  endtask

  task automatic test_divide;
    logic [15:0] as[11];
    logic [7:0]  bs[11];
    int   k;
    exp_t e;
    as = '{16'd1000, 16'd65535, 16'd65535, 16'd5, 16'd0, 16'd50000, 16'd12345, 16'd40000, 16'd0, 16'd0, 16'd0};
    bs = '{8'd7, 8'd255, 8'd1, 8'd9, 8'd200, 8'd123, 8'd1, 8'd250, 8'd0, 8'd0, 8'd0};
    for (int i = 8; i < 11; i++) begin
      as[i] = 16'($urandom);
      bs[i] = 8'($urandom_range(1, 255));
    end
    for (int i = 0; i < 11; i++) begin
      launch(as[i], bs[i]);
      wait_done(k);
      e = sb.pop_front();
      last_e = e;
      n_checks++;
      if (k !== 32) $display("FAIL latency %0d/%0d: got %0d cycles, required 32", as[i], bs[i], k);
      else n_pass++;
      n_checks++;
      if (quotient !== e.q || remainder !== e.r || bcd !== e.bcd || div_by_zero !== e.dbz || busy !== 1'b0)
        $display("FAIL result %0d/%0d: got q=%0d r=%0d bcd=%h dbz=%b busy=%b, required q=%0d r=%0d bcd=%h dbz=%b busy=0",
                 as[i], bs[i], quotient, remainder, bcd, div_by_zero, busy, e.q, e.r, e.bcd, e.dbz);
      else n_pass++;
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    int   bad;
    launch(16'd1234, 8'd0);
    e = sb.pop_front();
    last_e = e;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL dbz_timing: got done=%b busy=%b, required done=1 busy=0", done, busy);
    else n_pass++;
    n_checks++;
    if (quotient !== e.q || remainder !== e.r || bcd !== e.bcd || div_by_zero !== 1'b1)
      $display("FAIL dbz_result: got q=%h r=%h bcd=%h dbz=%b, required q=%h r=0 bcd=0 dbz=1",
               quotient, remainder, bcd, div_by_zero, e.q);
    else n_pass++;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL dbz_hold: got %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_start_ignored;
    exp_t prev, e;
    int   bad;
    prev = last_e;
    launch(16'd50000, 8'd123);
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      if (c == 9) begin dividend = 16'd7; divisor = 8'd0; start = 1'b1; end
      if (c == 10) start = 1'b0;
      if (done !== 1'b0 || busy !== 1'b1 || quotient !== prev.q || remainder !== prev.r ||
          bcd !== prev.bcd || div_by_zero !== prev.dbz) bad++;
      @(negedge clk);
    end
    e = sb.pop_front();
    last_e = e;
    n_checks++;
    if (bad != 0) $display("FAIL busy_hold: got %0d bad cycles, required 0", bad);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1) $display("FAIL ignore_done: got done=%b at cycle 32, required 1", done);
    else n_pass++;
    n_checks++;
    if (quotient !== e.q || remainder !== e.r || bcd !== e.bcd || div_by_zero !== 1'b0)
      $display("FAIL ignore_result: got q=%0d r=%0d bcd=%h dbz=%b, required q=%0d r=%0d bcd=%h dbz=0",
               quotient, remainder, bcd, div_by_zero, e.q, e.r, e.bcd);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   k, bad;
    launch(16'd60000, 8'd7);
    repeat (12) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({quotient, remainder, bcd, busy, done, div_by_zero} !== '0)
      $display("FAIL abort_reset: got q=%h r=%h bcd=%h busy=%b done=%b dbz=%b, required all 0",
               quotient, remainder, bcd, busy, done, div_by_zero);
    else n_pass++;
    void'(sb.pop_front());
    @(negedge clk); reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if ({quotient, remainder, bcd, busy, done, div_by_zero} !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_idle: got %0d bad cycles, required 0", bad);
    else n_pass++;
    launch(16'd100, 8'd3);
    wait_done(k);
    e = sb.pop_front();
    last_e = e;
    n_checks++;
    if (k !== 32 || quotient !== 16'd33 || remainder !== 8'd1 || bcd !== 24'h000033)
      $display("FAIL after_reset 100/3: got k=%0d q=%0d r=%0d bcd=%h, required k=32 q=33 r=1 bcd=000033",
               k, quotient, remainder, bcd);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   k;
    @(negedge clk);
    dividend = 16'd9999; divisor = 8'd99; start = 1'b1;
    sb.push_back(model(16'd9999, 8'd99));
    @(negedge clk);
    dividend = 16'd31415; divisor = 8'd16;
    sb.push_back(model(16'd31415, 8'd16));
    wait_done(k);
    e = sb.pop_front();
    n_checks++;
    if (k !== 32 || quotient !== e.q || remainder !== e.r || bcd !== e.bcd)
      $display("FAIL b2b_first: got k=%0d q=%0d r=%0d bcd=%h, required k=32 q=%0d r=%0d bcd=%h",
               k, quotient, remainder, bcd, e.q, e.r, e.bcd);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_accept: got done=%b busy=%b, required done=0 busy=1", done, busy);
    else n_pass++;
    start = 1'b0;
    wait_done(k);
    e = sb.pop_front();
    n_checks++;
    if (k !== 32 || quotient !== e.q || remainder !== e.r || bcd !== e.bcd || div_by_zero !== 1'b0)
      $display("FAIL b2b_second: got k=%0d q=%0d r=%0d bcd=%h, required k=32 q=%0d r=%0d bcd=%h",
               k, quotient, remainder, bcd, e.q, e.r, e.bcd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
